// File: rtl/arith_share_pkg.sv
// Shared helpers for the arith units that multiplex several requesters onto
// one datapath: requester-index width and round-robin pointer advance.
package arith_share_pkg;

    // Width of a requester index; never narrower than one bit.
    function automatic int calc_id_w(input int num);
        if (num <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(num);
        end
    endfunction

    // Round-robin pointer after granting idx: the slot just past it, wrapping.
    function automatic int rr_next_ptr(input int idx, input int num);
        if ((idx + 32'sd1) >= num) begin
            return 32'sd0;
        end else begin
            return idx + 32'sd1;
        end
    endfunction

endpackage : arith_share_pkg

// File: rtl/arith_fptoui.sv
// Combinational IEEE-754 (f32 or f64) to unsigned integer converter.
// Truncates toward zero; any negative input (including -0.0) gives 0.
// The value is formed as a 64-bit intermediate and its low OUT_WIDTH bits
// are returned. Magnitudes of 2^64 or more, infinities and NaNs produce an
// all-ones intermediate. The valid/ready pins pass straight through.
module arith_fptoui
    import arith_share_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data
);

    localparam int EXP_W  = (IN_WIDTH == 64) ? 11 : 8;
    localparam int FRAC_W = (IN_WIDTH == 64) ? 52 : 23;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

    generate
        if ((IN_WIDTH != 32) && (IN_WIDTH != 64)) begin : g_bad_width
            $fatal(1, "arith_fptoui: IN_WIDTH must be 32 or 64");
        end
    endgenerate

    logic              sign_s;
    logic [EXP_W-1:0]  exp_s;
    logic [FRAC_W-1:0] frac_s;
    logic [63:0]       mant_s;
    logic [63:0]       inter_s;

    assign sign_s = in_data[IN_WIDTH-1];
    assign exp_s  = in_data[IN_WIDTH-2 -: EXP_W];
    assign frac_s = in_data[FRAC_W-1:0];
    assign mant_s = 64'({1'b1, frac_s});

    // Align the significand by the unbiased exponent to get the integer part.
    always_comb begin
        int e_v;
        e_v     = int'(exp_s) - BIAS;
        inter_s = 64'd0;
        if (sign_s) begin
            inter_s = 64'd0;
        end else if (e_v < 0) begin
            inter_s = 64'd0;
        end else if (e_v >= 64) begin
            inter_s = {64{1'b1}};
        end else if (e_v >= FRAC_W) begin
            inter_s = mant_s << (e_v - FRAC_W);
        end else begin
            inter_s = mant_s >> (FRAC_W - e_v);
        end
    end

    assign out_data  = OUT_WIDTH'(inter_s);
    assign out_valid = in_valid;
    assign in_ready  = out_ready;

endmodule : arith_fptoui

// File: rtl/arith_fptoui_arb.sv
// Round-robin arbiter sharing one float-to-unsigned converter among NUM_REQ
// requesters. Grant is purely combinational from the eligible set and ptr;
// the only state is ptr and the one-entry output register, which reloads in
// the same cycle it drains so a result can leave every cycle.
module arith_fptoui_arb
    import arith_share_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  IN_WIDTH  = 32,
    parameter int  OUT_WIDTH = 32,
    localparam int ID_W      = calc_id_w(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_mask,
    input  logic [NUM_REQ-1:0]                in_valid,
    output logic [NUM_REQ-1:0]                in_ready,
    input  logic [NUM_REQ-1:0][IN_WIDTH-1:0]  in_data,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic [OUT_WIDTH-1:0]              result_data,
    output logic [ID_W-1:0]                   result_id,
    output logic                              busy
);

    logic [NUM_REQ-1:0]   eligible_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [ID_W-1:0]      grant_idx_s;
    logic                 found_s;
    logic                 load_en_s;
    logic                 transfer_s;
    logic [IN_WIDTH-1:0]  operand_s;
    logic [OUT_WIDTH-1:0] conv_data_s;
    logic                 conv_in_ready_s;
    logic                 conv_out_valid_s;

    logic [ID_W-1:0]      ptr_r;
    logic                 result_valid_r;
    logic [OUT_WIDTH-1:0] result_data_r;
    logic [ID_W-1:0]      result_id_r;

    assign eligible_s = in_valid & req_mask;

    // Search for the first eligible requester at or after ptr, wrapping.
    always_comb begin
        int idx;
        idx         = 0;
        found_s     = 1'b0;
        grant_idx_s = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && eligible_s[idx]) begin
                found_s     = 1'b1;
                grant_idx_s = ID_W'(idx);
            end else begin
                found_s     = found_s;
            end
        end
    end

    // One-hot grant vector for the winning index.
    always_comb begin
        grant_s = {NUM_REQ{1'b0}};
        if (found_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = {NUM_REQ{1'b0}};
        end
    end

    assign operand_s  = in_data[grant_idx_s];
    assign load_en_s  = (!result_valid_r || result_ready) && conv_in_ready_s && conv_out_valid_s;
    assign transfer_s = found_s && load_en_s;
    assign in_ready   = grant_s & {NUM_REQ{load_en_s && !rst}};
    assign busy       = result_valid_r || (|eligible_s);

    arith_fptoui #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_conv (
        .in_valid  (1'b1),
        .in_ready  (conv_in_ready_s),
        .in_data   (operand_s),
        .out_valid (conv_out_valid_s),
        .out_ready (1'b1),
        .out_data  (conv_data_s)
    );

    // Advance the round-robin pointer past each granted requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {ID_W{1'b0}};
        end else if (transfer_s) begin
            ptr_r <= ID_W'(rr_next_ptr(int'(grant_idx_s), NUM_REQ));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Output register: load on transfer, clear on drain, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_r <= 1'b0;
            result_data_r  <= {OUT_WIDTH{1'b0}};
            result_id_r    <= {ID_W{1'b0}};
        end else if (transfer_s) begin
            result_valid_r <= 1'b1;
            result_data_r  <= conv_data_s;
            result_id_r    <= grant_idx_s;
        end else if (result_ready) begin
            result_valid_r <= 1'b0;
            result_data_r  <= result_data_r;
            result_id_r    <= result_id_r;
        end else begin
            result_valid_r <= result_valid_r;
            result_data_r  <= result_data_r;
            result_id_r    <= result_id_r;
        end
    end

    assign result_valid = result_valid_r;
    assign result_data  = result_data_r;
    assign result_id    = result_id_r;

endmodule : arith_fptoui_arb
